// File: rtl/deser_pkg.sv
// Shared types and helpers for the port2 deserializer.
// Used by port2_deserializer; parity framing is selected there via DESER_PARITY_EN.
package deser_pkg;

   typedef enum logic {IDLE, SHIFT} state_t;

   // Bits needed to count 0..n-1 (never less than one).
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                           input logic [31:0] max);
      return (value == max) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/deser_fifo.sv
// Word buffer for the deserializer: circular storage with an extra pointer bit
// to tell full from empty. Head reads as zero while empty.
module deser_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A push into a full buffer is taken only when a pop frees the slot on the same edge.
   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/port2_deserializer.sv
// Serial-to-word deserializer (LSB first, sync-framed) feeding a small FIFO.
// Define DESER_PARITY_EN for a trailing even-parity bit per frame and par_err_cnt.
module port2_deserializer
   import deser_pkg::*;
#(
   parameter int unsigned WORD_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned OVF_W      = 8
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic              bit_in,
   input  logic              bit_valid,
   input  logic              frame_sync,
   output logic [WORD_W-1:0] word_out,
   output logic              word_valid,
   input  logic              word_ready,
   output logic              fifo_full,
   output logic [OVF_W-1:0]  ovf_cnt
`ifdef DESER_PARITY_EN
   ,
   output logic [OVF_W-1:0]  par_err_cnt
`endif
);

`ifdef DESER_PARITY_EN
   localparam int unsigned FRAME_W = WORD_W + 1;
`else
   localparam int unsigned FRAME_W = WORD_W;
`endif
   localparam int unsigned CW = cnt_width(FRAME_W);
   localparam logic [CW-1:0]    LAST_IDX = CW'(FRAME_W - 1);
   localparam logic [OVF_W-1:0] CNT_MAX  = '1;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [WORD_W-1:0] shift, shift_n;
   logic              frame_done;
   logic              par_ok;
   logic              push;
   logic              drop;
   logic              empty;
   logic [OVF_W-1:0]  ovf_q;

   always_ff @(posedge clk1) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         shift <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         shift <= shift_n;
      end
   end

   // shift_n already carries the current bit, so it doubles as the completed word.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      shift_n    = shift;
      frame_done = 1'b0;
      if (bit_valid) begin
         if (frame_sync) begin
            shift_n    = '0;
            shift_n[0] = bit_in;
            cnt_n      = CW'(1);
            state_n    = SHIFT;
         end else if (state == SHIFT) begin
            for (int unsigned i = 0; i < WORD_W; i++) begin
               if (cnt == CW'(i)) shift_n[i] = bit_in;
            end
            if (cnt == LAST_IDX) begin
               frame_done = 1'b1;
               cnt_n      = '0;
               state_n    = IDLE;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
      end
   end

`ifdef DESER_PARITY_EN
   // The parity bit never lands in the shift register; it is checked against the data bits.
   assign par_ok = ((^shift) == bit_in);
`else
   assign par_ok = 1'b1;
`endif

   assign push = frame_done & par_ok;
   assign drop = push & fifo_full & ~word_ready;

   deser_fifo #(
      .WIDTH (WORD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk1),
      .rst       (rst),
      .push      (push),
      .push_data (shift_n),
      .pop       (word_ready),
      .head      (word_out),
      .full      (fifo_full),
      .empty     (empty)
   );

   assign word_valid = ~empty;

   always_ff @(posedge clk1) begin
      if (rst) begin
         ovf_q <= '0;
      end else if (drop) begin
         ovf_q <= OVF_W'(sat_inc(32'(ovf_q), 32'(CNT_MAX)));
      end
   end

   assign ovf_cnt = ovf_q;

`ifdef DESER_PARITY_EN
   logic [OVF_W-1:0] par_q;

   always_ff @(posedge clk1) begin
      if (rst) begin
         par_q <= '0;
      end else if (frame_done && !par_ok) begin
         par_q <= OVF_W'(sat_inc(32'(par_q), 32'(CNT_MAX)));
      end
   end

   assign par_err_cnt = par_q;
`endif

endmodule

// File: tb/tb_port2_deserializer.sv
// Scoreboard bench for port2_deserializer: a frame/queue reference model predicts
// accepted words and counters; a negedge monitor compares against the DUT.
module tb_port2_deserializer;

   localparam int unsigned WORD_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned OVF_W  = 8;
   localparam int unsigned SAT    = (1 << OVF_W) - 1;
`ifdef DESER_PARITY_EN
   localparam int unsigned FRAME_W = WORD_W + 1;
`else
   localparam int unsigned FRAME_W = WORD_W;
`endif

   logic              clk1 = 1'b0;
   logic              rst = 1'b1;
   logic              bit_in = 1'b0;
   logic              bit_valid = 1'b0;
   logic              frame_sync = 1'b0;
   logic              word_ready = 1'b0;
   logic [WORD_W-1:0] word_out;
   logic              word_valid;
   logic              fifo_full;
   logic [OVF_W-1:0]  ovf_cnt;
`ifdef DESER_PARITY_EN
   logic [OVF_W-1:0]  par_err_cnt;
`endif

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   always #5 clk1 = ~clk1;

   port2_deserializer #(
      .WORD_W     (WORD_W),
      .FIFO_DEPTH (DEPTH),
      .OVF_W      (OVF_W)
   ) dut (
      .clk1       (clk1),
      .rst        (rst),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .frame_sync (frame_sync),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .fifo_full  (fifo_full),
      .ovf_cnt    (ovf_cnt)
`ifdef DESER_PARITY_EN
      ,
      .par_err_cnt(par_err_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frames are lists of bits, the FIFO is a queue plus an occupancy count.
   logic [WORD_W-1:0] exp_q[$];
   int                occ = 0;
   int unsigned       m_ovf = 0;
   int unsigned       m_par = 0;
   bit                framing = 1'b0;
   bit                frame_bits[$];

   always @(posedge clk1) begin
      bit                pop_now;
      bit                have;
      bit                good;
      logic [WORD_W-1:0] w;
      if (rst) begin
         occ = 0;
         exp_q.delete();
         framing = 1'b0;
         frame_bits.delete();
         m_ovf = 0;
         m_par = 0;
      end else begin
         pop_now = (occ > 0) && word_ready;
         have = 1'b0;
         w = '0;
         if (bit_valid) begin
            if (frame_sync) begin
               framing = 1'b1;
               frame_bits.delete();
               frame_bits.push_back(bit_in);
            end else if (framing) begin
               frame_bits.push_back(bit_in);
            end
            if (framing && frame_bits.size() == FRAME_W) begin
               for (int unsigned i = 0; i < WORD_W; i++) w[i] = frame_bits[i];
               good = 1'b1;
`ifdef DESER_PARITY_EN
               good = ((^w) == frame_bits[WORD_W]);
`endif
               framing = 1'b0;
               frame_bits.delete();
               if (good) have = 1'b1;
               else if (m_par < SAT) m_par++;
            end
         end
         if (pop_now) occ--;
         if (have) begin
            if (occ < DEPTH) begin
               occ++;
               exp_q.push_back(w);
            end else if (m_ovf < SAT) begin
               m_ovf++;
            end
         end
      end
   end

   // Monitor: compare the head word on every cycle it is presented, pop on handshake.
   always @(negedge clk1) begin
      if (started) begin
         chk("word_valid", 32'(word_valid), 32'(occ > 0));
         chk("fifo_full", 32'(fifo_full), 32'(occ == DEPTH));
         chk("ovf_cnt", 32'(ovf_cnt), m_ovf);
`ifdef DESER_PARITY_EN
         chk("par_err_cnt", 32'(par_err_cnt), m_par);
`endif
         if (word_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("spurious_word", 32'(word_valid), 32'd0);
            end else begin
               chk("word_out", 32'(word_out), 32'(exp_q[0]));
               if (word_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic step(input bit v, input bit s, input bit b, input bit r, input bit rs);
      bit_valid  = v;
      frame_sync = s;
      bit_in     = b;
      word_ready = r;
      rst        = rs;
      @(posedge clk1);
      #1;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, r, 1'b0);
   endtask

   task automatic send_word(input logic [WORD_W-1:0] w, input bit r, input bit r_last,
                            input bit bad_par);
      bit b;
      for (int unsigned i = 0; i < FRAME_W; i++) begin
         b = (i < WORD_W) ? w[i] : ((^w) ^ bad_par);
         step(1'b1, i == 0, b, (i == FRAME_W - 1) ? r_last : r, 1'b0);
      end
   endtask

   initial begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      started = 1'b1;
      chk("reset_word_valid", 32'(word_valid), 32'd0);
      chk("reset_word_out", 32'(word_out), 32'd0);
      chk("reset_fifo_full", 32'(fifo_full), 32'd0);
      chk("reset_ovf_cnt", 32'(ovf_cnt), 32'd0);
      idle(2, 1'b1);

      // 8'h4D LSB first, visible right after the edge that takes the last bit.
      send_word(8'h4D, 1'b1, 1'b1, 1'b0);
      chk("latency_valid", 32'(word_valid), 32'd1);
      chk("latency_word", 32'(word_out), 32'h4D);
      idle(2, 1'b1);
      chk("single_pop", 32'(word_valid), 32'd0);

      // Unsynced bit ignored, restart at bit 3 discards the partial word.
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      send_word(8'hA5, 1'b1, 1'b1, 1'b0);
      chk("resync_word", 32'(word_out), 32'hA5);
      idle(3, 1'b1);

      // Overflow: five words into a four-deep buffer with no reader.
      for (int k = 1; k <= 5; k++) begin
         send_word(WORD_W'(k), 1'b0, 1'b0, 1'b0);
         if (k == 4) chk("full_after_4", 32'(fifo_full), 32'd1);
      end
      chk("ovf_after_5", 32'(ovf_cnt), 32'd1);
      idle(6, 1'b1);

      // Full buffer with a pop on the same edge as the push.
      for (int k = 0; k < 4; k++) send_word(WORD_W'(8'h10 + k), 1'b0, 1'b0, 1'b0);
      send_word(8'h77, 1'b0, 1'b1, 1'b0);
      chk("push_pop_ovf", 32'(ovf_cnt), 32'd1);
      chk("push_pop_full", 32'(fifo_full), 32'd1);
      idle(6, 1'b1);

      // Reset mid-word with two words buffered.
      send_word(8'h21, 1'b0, 1'b0, 1'b0);
      send_word(8'h22, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rst_mid_valid", 32'(word_valid), 32'd0);
      chk("rst_mid_ovf", 32'(ovf_cnt), 32'd0);
      send_word(8'h5A, 1'b1, 1'b1, 1'b0);
      chk("post_rst_word", 32'(word_out), 32'h5A);
      idle(3, 1'b1);

`ifdef DESER_PARITY_EN
      send_word(8'h03, 1'b1, 1'b1, 1'b1);
      chk("par_bad_cnt", 32'(par_err_cnt), 32'd1);
      chk("par_bad_drop", 32'(word_valid), 32'd0);
      send_word(8'h03, 1'b1, 1'b1, 1'b0);
      chk("par_good_word", 32'(word_out), 32'h03);
      idle(3, 1'b1);
`endif

      // Saturation of the overflow counter.
      for (int k = 0; k < 4 + SAT + 5; k++) send_word(WORD_W'($urandom), 1'b0, 1'b0, 1'b0);
      chk("ovf_saturated", 32'(ovf_cnt), SAT);
      idle(6, 1'b1);

      // Random traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, 1'($urandom),
              1'($urandom), $urandom_range(0, 499) == 0);
      end
      idle(8, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
